// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory and
// fills the IF/ID register, with stall, branch redirect and halt handling.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 16'd63,
  parameter logic [15:0]       NOP_INSTR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc_addr,
  input  logic [15:0]       instr_in,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt_req,
  output logic [15:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc1,
  output logic              if_id_valid,
  output logic              halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc1_q, pc1_d;
  logic              valid_q, valid_d;
  logic              halted_q;
  logic              at_last;
  logic              past_last;

  assign at_last   = (pc_q == LAST_ADDR);
  assign past_last = (pc_q > LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (br_taken) begin
          state_d = RUN;
        end else if (stall) begin
          state_d = RUN;
        end else if (halt_req || past_last || at_last) begin
          state_d = HALT;
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // Default is to hold; every non-hold path either bubbles or captures.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    unique case (state_q)
      RUN: begin
        if (br_taken) begin
          pc_d    = br_target;
          instr_d = NOP_INSTR;
          pc1_d   = '0;
          valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (halt_req || past_last) begin
          instr_d = NOP_INSTR;
          pc1_d   = '0;
          valid_d = 1'b0;
        end else begin
          instr_d = instr_in;
          pc1_d   = pc_q + ADDR_W'(1);
          valid_d = 1'b1;
          if (!at_last) begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        instr_d = NOP_INSTR;
        pc1_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      instr_q  <= NOP_INSTR;
      pc1_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc1_q    <= pc1_d;
      valid_q  <= valid_d;
      halted_q <= (state_q == HALT);
    end
  end

  assign pc_addr     = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc1   = pc1_q;
  assign if_id_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the 16-bit pipelined datapath.
- Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register.
- Handles load-use stalls, taken-branch (BNE) redirect with flush, and a halt condition.

Parameters:
ADDR_W, 16, width of PC / instruction memory word address
LAST_ADDR, 16'd63, highest valid instruction word address; fetching past it enters HALT
NOP_INSTR, 16'h0000, instruction value inserted into IF/ID on bubble/flush

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
pc_addr  output  ADDR_W  word address to instruction memory (current PC)
instr_in  input  16  instruction returned combinationally for pc_addr
stall  input  1  hazard unit: hold PC and IF/ID contents
br_taken  input  1  branch resolved taken this cycle
br_target  input  ADDR_W  absolute word address of branch target
halt_req  input  1  external request to stop fetching
if_id_instr  output  16  registered instruction for decode ([15:12] opcode, [11:8] Rs, [7:4] Rt, [3:0] Rd/offset)
if_id_pc1  output  ADDR_W  registered PC+1 of the instruction in if_id_instr
if_id_valid  output  1  1 = if_id_instr is a real fetched instruction; 0 = bubble
halted  output  1  1 while in HALT state

Behaviour:
- Reset is synchronous and active-high on rst; the block has one clock, clk.
- While rst=1 at a clock edge, the block resets to:
  - pc_addr=0
  - if_id_instr=NOP_INSTR
  - if_id_pc1=0
  - if_id_valid=0
  - halted=0
  - state=BOOT
- Reset asserted mid-operation (including during stall or HALT) overrides everything at that edge.
- State machine:
  - BOOT: one cycle. IF/ID stays a bubble; PC is not advanced. Next state is RUN. This gives the memory one full cycle of valid address.
  - RUN: normal fetch.
  - HALT: terminal until rst.
- RUN, per edge, priority br_taken > stall > halt > normal:
  - br_taken=1: pc_addr<=br_target; IF/ID<=bubble (NOP_INSTR, valid=0, pc1=0). The instruction fetched this cycle is discarded. br_taken overrides stall in the same cycle.
  - stall=1 (no branch): pc_addr, if_id_instr, if_id_pc1 and if_id_valid all hold.
  - halt_req=1: state<=HALT; IF/ID<=bubble; PC holds.
  - Normal, pc_addr<=LAST_ADDR: if_id_instr<=instr_in; if_id_pc1<=pc_addr+1; if_id_valid<=1.
    - If pc_addr==LAST_ADDR, PC holds and state<=HALT after capturing this last instruction. There is no wrap-around.
    - Otherwise pc_addr<=pc_addr+1.
  - pc_addr>LAST_ADDR (only reachable via br_target): treated as halt. State<=HALT; IF/ID<=bubble; the fetched word is not captured.
- HALT:
  - halted=1 (registered, asserted the edge after entry).
  - PC frozen.
  - IF/ID<=bubble each edge regardless of stall.
  - br_taken and halt_req are ignored.
- Latency: the instruction at address A appears on if_id_instr one edge after pc_addr==A, absent stall or branch.
- Arithmetic: PC+1 is modulo 2^ADDR_W. No sign extension is done here; branch offset arithmetic is the branch unit's job, and br_target is already absolute.
- pc_addr is a pure register output, with no combinational path from any input.

Test Plan:
- Reset then free run, memory holding word value = 16'h1000+addr:
  - Edge 1 after rst release: valid=0 (BOOT).
  - Next edges: if_id_instr=16'h1000,16'h1001,16'h1002.
  - if_id_pc1=1,2,3.
  - pc_addr increments by 1.
- Stall for 2 cycles at pc_addr=5 -> pc_addr stays 5, if_id_instr stays 16'h1004 with valid=1; fetch resumes with 16'h1005 on the first edge after stall drops.
- br_taken=1, br_target=4 while pc_addr=7 (same cycle also stall=1):
  - Next edge: pc_addr=4, IF/ID valid=0 instr=16'h0000.
  - Following edge: if_id_instr=16'h1004.
- LAST_ADDR=10, run to the end:
  - Address 10's instruction is captured with valid=1 and if_id_pc1=11.
  - Next edge: valid=0; halted=1 thereafter.
  - pc_addr stays 10; br_taken pulse is ignored.
- br_target=40 with LAST_ADDR=10 -> enters HALT, no valid instruction from address 40 ever appears.
- rst asserted for one edge while in HALT, and again mid-stall at pc_addr=3 -> all outputs return to reset values, BOOT bubble, then fetch restarts from address 0.
